// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and constants for the UART receive monitor.
//
// Contents:
//   rx_state_t      receiver FSM states
//   rx_entry_t      one FIFO entry: {perr, ferr, data}, data sized for the
//                   widest legal character (8 bits) and zero-extended below that
//   ENTRY_W         packed width of rx_entry_t
//   RX_SYNC_RST     reset value of the rx synchroniser flops (line idle level)
//   even_parity()   XOR reduction used by the optional parity check
//
// The optional parity path is compiled in when UART_RX_MONITOR_PARITY_EN is defined.
package uart_rx_monitor_pkg;

  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  typedef struct packed {
    logic                     perr;
    logic                     ferr;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  localparam int   ENTRY_W     = $bits(rx_entry_t);
  localparam logic RX_SYNC_RST = 1'b1;

  function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding received characters.
//
// Parameters:
//   WIDTH   entry width
//   LOG2    depth = 2**LOG2 entries
// Ports:
//   i_clk    clock
//   i_nrst   synchronous active-low reset (empties the FIFO)
//   i_push   write i_data when not full, or when full and a pop happens this cycle
//   i_pop    remove head entry (ignored when empty)
//   i_data   write data
//   o_data   head entry, valid whenever o_empty is 0
//   o_count  occupancy, 0..2**LOG2
//   o_full   occupancy == 2**LOG2
//   o_empty  occupancy == 0
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int LOG2  = 4
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [LOG2:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2:0]    wr_ptr;
  logic [LOG2:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign o_count = wr_ptr - rd_ptr;
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (o_count == (LOG2+1)'(DEPTH));

  // A pop frees the head slot in the same cycle, so a push on a full FIFO
  // is accepted when it coincides with a pop.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (LOG2+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (LOG2+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[LOG2-1:0]] <= i_data;
  end

  assign o_data = mem[rd_ptr[LOG2-1:0]];

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: oversampling 8N1-style receiver (optionally with even
// parity), an RX FIFO and sticky overflow reporting behind a valid/ready port.
//
// Build option: define UART_RX_MONITOR_PARITY_EN to add one even-parity bit per
// frame (frame = start + DATA_BITS + parity + stop). Without it there is no
// parity bit and o_rperr is always 0.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8), LSB first
//   OVERSAMPLE  sample ticks per bit (power of 2, >= 4)
//   FIFO_LOG2   FIFO depth = 2**FIFO_LOG2
//   SCALER_W    width of i_scaler
// Ports:
//   i_clk       system clock
//   i_nrst      synchronous active-low reset
//   i_scaler    clk cycles per sample tick (0 behaves as 1)
//   i_rx        asynchronous serial line, idle high
//   i_rready    consumer accepts head entry
//   o_rvalid    FIFO non-empty
//   o_rdata     head character
//   o_rferr     head character had a framing error
//   o_rperr     head character had a parity error
//   o_count     FIFO occupancy
//   i_clr_err   clears o_overflow
//   o_overflow  sticky: a character was dropped because the FIFO was full
//   o_busy      receiver not idle
module uart_rx_monitor
  import uart_rx_monitor_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int FIFO_LOG2  = 4,
  parameter int SCALER_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic [SCALER_W-1:0]  i_scaler,
  input  logic                 i_rx,
  input  logic                 i_rready,
  output logic                 o_rvalid,
  output logic [DATA_BITS-1:0] o_rdata,
  output logic                 o_rferr,
  output logic                 o_rperr,
  output logic [FIFO_LOG2:0]   o_count,
  input  logic                 i_clr_err,
  output logic                 o_overflow,
  output logic                 o_busy
);

  localparam int              OS_W     = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0] OS_END   = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_t             state;
  logic                  rx_p0, rx_p1, rx_p2;
  logic                  rx_line;
  logic                  rx_fall;
  logic [SCALER_W-1:0]   scaler_m1;
  logic [SCALER_W-1:0]   tick_cnt;
  logic [SCALER_W-1:0]   tick_lim;
  logic                  tick;
  logic [OS_W-1:0]       s_cnt;
  logic [3:0]            bit_cnt;
  logic                  samp_end;
  logic [DATA_BITS-1:0]  shreg;
  logic                  perr_q;
  logic                  push;
  rx_entry_t             push_entry;
  logic [ENTRY_W-1:0]    head_bits;
  rx_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  ovf_evt;
  logic                  overflow_q;

  // ---- Stage p0/p1: two-flop synchroniser; p2 keeps history for edge detect
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      rx_p0 <= RX_SYNC_RST;
      rx_p1 <= RX_SYNC_RST;
      rx_p2 <= RX_SYNC_RST;
    end else begin
      rx_p0 <= i_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_line = rx_p1;
  assign rx_fall = rx_p2 & ~rx_p1;

  // ---- Sample-tick generator
  // The reload limit is latched only while idle or at a tick, so a scaler
  // change mid-count never stretches or truncates the current tick period.
  assign scaler_m1 = (i_scaler == '0) ? '0 : i_scaler - SCALER_W'(1);
  assign tick      = (state != IDLE) && (tick_cnt == tick_lim);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      tick_cnt <= '0;
      tick_lim <= '0;
    end else if (state == IDLE || tick) begin
      tick_cnt <= '0;
      tick_lim <= scaler_m1;
    end else begin
      tick_cnt <= tick_cnt + SCALER_W'(1);
    end
  end

  assign samp_end = tick && (s_cnt == OS_END);

  // ---- Receiver FSM
  // START decides at the half-bit tick; from then on every OVERSAMPLE ticks
  // lands in the middle of the next bit. s_cnt wraps naturally at OVERSAMPLE.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state   <= IDLE;
      s_cnt   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fall) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == OS_MID) begin
              s_cnt   <= '0;
              bit_cnt <= '0;
              state   <= rx_line ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + OS_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            s_cnt <= s_cnt + OS_W'(1);
            if (s_cnt == OS_END) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_MONITOR_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end
        PARITY: begin
          if (tick) begin
            s_cnt <= s_cnt + OS_W'(1);
            if (s_cnt == OS_END) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            s_cnt <= s_cnt + OS_W'(1);
            if (s_cnt == OS_END) state <= rx_line ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // A long break must not re-trigger: require a full bit time of
          // uninterrupted high line before listening for a new start bit.
          if (!rx_line) begin
            s_cnt <= '0;
          end else if (tick) begin
            s_cnt <= s_cnt + OS_W'(1);
            if (s_cnt == OS_END) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          s_cnt <= '0;
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE);

  // ---- Character assembly (datapath, not reset)
  always_ff @(posedge i_clk) begin
    if (state == DATA && samp_end) shreg <= {rx_line, shreg[DATA_BITS-1:1]};
  end

`ifdef UART_RX_MONITOR_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (state == PARITY && samp_end)
      perr_q <= rx_line ^ even_parity(MAX_DATA_BITS'(shreg));
  end
`else
  assign perr_q = 1'b0;
`endif

  // Push happens on the stop-bit mid-sample itself; a low stop bit is a
  // framing error but the character is still delivered.
  assign push            = (state == STOP) && samp_end;
  assign push_entry.perr = perr_q;
  assign push_entry.ferr = ~rx_line;
  assign push_entry.data = MAX_DATA_BITS'(shreg);

  // ---- FIFO and read port
  assign pop = ~fifo_empty & i_rready;

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (push_entry),
    .o_data  (head_bits),
    .o_count (o_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign head     = rx_entry_t'(head_bits);
  assign o_rvalid = ~fifo_empty;
  // Head fields are masked while empty so the port reads 0 after reset even
  // though the storage array itself is not cleared.
  assign o_rdata  = fifo_empty ? '0 : head.data[DATA_BITS-1:0];
  assign o_rferr  = ~fifo_empty & head.ferr;
  assign o_rperr  = ~fifo_empty & head.perr;

  // A same-cycle pop makes room, so only an unmatched push on full drops.
  assign ovf_evt = push & fifo_full & ~pop;

  always_ff @(posedge i_clk) begin
    if (!i_nrst)        overflow_q <= 1'b0;
    else if (ovf_evt)   overflow_q <= 1'b1;
    else if (i_clr_err) overflow_q <= 1'b0;
  end

  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
module tb_uart_rx_monitor;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 8;
  localparam int FIFO_LOG2  = 4;
  localparam int SCALER_W   = 16;
  localparam int DEPTH      = 1 << FIFO_LOG2;
`ifdef UART_RX_MONITOR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 i_nrst;
  logic [SCALER_W-1:0]  i_scaler;
  logic                 i_rx;
  logic                 i_rready;
  logic                 o_rvalid;
  logic [DATA_BITS-1:0] o_rdata;
  logic                 o_rferr;
  logic                 o_rperr;
  logic [FIFO_LOG2:0]   o_count;
  logic                 i_clr_err;
  logic                 o_overflow;
  logic                 o_busy;

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_LOG2  (FIFO_LOG2),
    .SCALER_W   (SCALER_W)
  ) dut (
    .i_clk      (clk),
    .i_nrst     (i_nrst),
    .i_scaler   (i_scaler),
    .i_rx       (i_rx),
    .i_rready   (i_rready),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .o_rferr    (o_rferr),
    .o_rperr    (o_rperr),
    .o_count    (o_count),
    .i_clr_err  (i_clr_err),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO as a bounded queue of received characters.
  typedef struct {
    logic [7:0] d;
    logic       ferr;
    logic       perr;
  } exp_t;
  exp_t model_q[$];

  int         lat;
  bit         seen;
  logic [7:0] cap;

  function automatic int bit_clk(input int sc);
    return ((sc == 0) ? 1 : sc) * OVERSAMPLE;
  endfunction

  function automatic logic exp_perr(input logic bad);
    return PAR_EN ? bad : 1'b0;
  endfunction

  // Returns 1 when the model accepted the character, 0 when it was dropped.
  function automatic bit model_push(input logic [7:0] d, input logic ferr, input logic perr);
    exp_t e;
    e.d = d; e.ferr = ferr; e.perr = perr;
    if (model_q.size() < DEPTH) begin
      model_q.push_back(e);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Caller is positioned just after a rising edge.
  task automatic drive_bit(input logic b, input int n);
    i_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    i_rready = 1'b1;
    @(posedge clk); #1;
    i_rready = 1'b0;
  endtask

  // Sends one frame at the current scaler. pop_at/clr_at (>=0) pulse i_rready /
  // i_clr_err for one cycle at that offset into the stop bit. Reports the number
  // of edges from stop-bit start until o_count changed, and the first o_rdata
  // seen valid during the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad,
                            input int extra_low, input int pop_at, input int clr_at,
                            output int lat_o, output bit seen_o, output logic [7:0] cap_o);
    int bc;
    int c0;
    bc = bit_clk(int'(i_scaler));
    lat_o = -1; seen_o = 1'b0; cap_o = 8'h00;
    drive_bit(1'b0, bc);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], bc);
    if (PAR_EN) drive_bit((^d) ^ par_bad, bc);
    c0 = int'(o_count);
    i_rx = stop_b;
    for (int i = 0; i < bc; i++) begin
      if (pop_at >= 0) i_rready  = (i == pop_at);
      if (clr_at >= 0) i_clr_err = (i == clr_at);
      @(posedge clk); #1;
      if (lat_o < 0 && int'(o_count) != c0) lat_o = i + 1;
      if (!seen_o && o_rvalid) begin seen_o = 1'b1; cap_o = o_rdata; end
    end
    if (pop_at >= 0) i_rready = 1'b0;
    if (clr_at >= 0) i_clr_err = 1'b0;
    if (extra_low > 0) begin
      i_rx = 1'b0;
      repeat (extra_low * bc) @(posedge clk);
      #1;
    end
    i_rx = 1'b1;
    repeat (2 * bc) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_nrst = 1'b0; i_rx = 1'b1; i_rready = 1'b0; i_clr_err = 1'b0; i_scaler = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_rvalid, o_rferr, o_rperr, o_overflow, o_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b expected=00000", {o_rvalid, o_rferr, o_rperr, o_overflow, o_busy});
    end
    n_checks++;
    if (o_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d expected=0", o_count); end
    n_checks++;
    if (o_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h expected=00", o_rdata); end
    i_nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_8n1();
    send_frame(8'h55, 1'b1, 1'b0, 0, -1, -1, lat, seen, cap);
    n_checks++;
    if (lat < 16 || lat > 22) begin n_fail++; $display("FAIL basic_latency got=%0d expected=16..22", lat); end
    n_checks++;
    if (o_rvalid !== 1'b1) begin n_fail++; $display("FAIL basic_rvalid got=%b expected=1", o_rvalid); end
    n_checks++;
    if (o_rdata !== 8'h55) begin n_fail++; $display("FAIL basic_rdata got=%h expected=55", o_rdata); end
    n_checks++;
    if ({o_rferr, o_rperr} !== 2'b00) begin n_fail++; $display("FAIL basic_err got=%b expected=00", {o_rferr, o_rperr}); end
    n_checks++;
    if (o_count !== 5'd1) begin n_fail++; $display("FAIL basic_count got=%0d expected=1", o_count); end
    pop_one();
    n_checks++;
    if ({o_rvalid, o_count} !== 6'd0) begin
      n_fail++; $display("FAIL basic_pop got rvalid=%b count=%0d expected 0/0", o_rvalid, o_count);
    end
  endtask

  task automatic test_glitch();
    int t_rise;
    int t_fall;
    t_rise = -1; t_fall = -1;
    i_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rx = 1'b1;
    for (int i = 0; i < 80 && t_fall < 0; i++) begin
      @(posedge clk); #1;
      if (o_busy && t_rise < 0) t_rise = i;
      if (!o_busy && t_rise >= 0) t_fall = i;
    end
    n_checks++;
    if (t_rise < 0 || t_fall < 0) begin
      n_fail++; $display("FAIL glitch_busy_timeout got rise=%0d fall=%0d expected both seen", t_rise, t_fall);
    end
    n_checks++;
    if (t_fall - t_rise > 16 || t_fall - t_rise < 1) begin
      n_fail++; $display("FAIL glitch_busy_len got=%0d expected=1..16", t_fall - t_rise);
    end
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (o_count !== '0 || o_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_push got count=%0d expected=0", o_count);
    end
  endtask

  task automatic test_empty_passthrough();
    i_rready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 0, -1, -1, lat, seen, cap);
    i_rready = 1'b0;
    n_checks++;
    if (seen !== 1'b1 || cap !== 8'h5A) begin
      n_fail++; $display("FAIL passthrough_data got seen=%b data=%h expected 1/5a", seen, cap);
    end
    n_checks++;
    if (o_count !== '0) begin n_fail++; $display("FAIL passthrough_count got=%0d expected=0", o_count); end
  endtask

  task automatic test_framing_break();
    send_frame(8'hA3, 1'b0, 1'b0, 100, -1, -1, lat, seen, cap);
    n_checks++;
    if (o_count !== 5'd1) begin n_fail++; $display("FAIL break_count got=%0d expected=1", o_count); end
    n_checks++;
    if (o_rdata !== 8'hA3 || o_rferr !== 1'b1) begin
      n_fail++; $display("FAIL break_entry got data=%h ferr=%b expected a3/1", o_rdata, o_rferr);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL break_idle got busy=%b expected=0", o_busy); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    bit         acc;
    model_q.delete();
    for (int k = 0; k < DEPTH + 1; k++) begin
      d = 8'($urandom_range(0, 255));
      acc = model_push(d, 1'b0, 1'b0);
      send_frame(d, 1'b1, 1'b0, 0, -1, -1, lat, seen, cap);
    end
    n_checks++;
    if (o_count !== 5'(DEPTH)) begin n_fail++; $display("FAIL ovf_count got=%0d expected=%0d", o_count, DEPTH); end
    n_checks++;
    if (o_overflow !== !acc) begin n_fail++; $display("FAIL ovf_flag got=%b expected=%b", o_overflow, !acc); end
    n_checks++;
    if (o_rdata !== model_q[0].d) begin n_fail++; $display("FAIL ovf_head got=%h expected=%h", o_rdata, model_q[0].d); end
    // Clear requested on the very cycle of another drop: the drop must win.
    d = 8'($urandom_range(0, 255));
    acc = model_push(d, 1'b0, 1'b0);
    send_frame(d, 1'b1, 1'b0, 0, -1, 18, lat, seen, cap);
    n_checks++;
    if (o_overflow !== !acc) begin n_fail++; $display("FAIL ovf_clr_collision got=%b expected=%b", o_overflow, !acc); end
    i_clr_err = 1'b1;
    @(posedge clk); #1;
    i_clr_err = 1'b0;
    n_checks++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b expected=0", o_overflow); end
    // Pop on the push cycle while full.
    d = 8'($urandom_range(0, 255));
    void'(model_q.pop_front());
    acc = model_push(d, 1'b0, 1'b0);
    send_frame(d, 1'b1, 1'b0, 0, 18, -1, lat, seen, cap);
    n_checks++;
    if (o_overflow !== !acc || o_count !== 5'(model_q.size())) begin
      n_fail++; $display("FAIL ovf_pop_push got ovf=%b count=%0d expected %b/%0d", o_overflow, o_count, !acc, model_q.size());
    end
    while (model_q.size() > 0) begin
      exp_t e;
      e = model_q.pop_front();
      n_checks++;
      if (o_rvalid !== 1'b1 || o_rdata !== e.d || o_rferr !== e.ferr) begin
        n_fail++; $display("FAIL ovf_drain got v=%b d=%h f=%b expected 1/%h/%b", o_rvalid, o_rdata, o_rferr, e.d, e.ferr);
      end
      pop_one();
    end
    n_checks++;
    if (o_count !== '0) begin n_fail++; $display("FAIL ovf_empty got=%0d expected=0", o_count); end
  endtask

`ifdef UART_RX_MONITOR_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1, 0, -1, -1, lat, seen, cap);
    send_frame(8'h07, 1'b1, 1'b0, 0, -1, -1, lat, seen, cap);
    n_checks++;
    if (o_rdata !== 8'h07 || o_rperr !== 1'b1) begin
      n_fail++; $display("FAIL parity_bad got d=%h perr=%b expected 07/1", o_rdata, o_rperr);
    end
    pop_one();
    n_checks++;
    if (o_rdata !== 8'h07 || o_rperr !== 1'b0) begin
      n_fail++; $display("FAIL parity_good got d=%h perr=%b expected 07/0", o_rdata, o_rperr);
    end
    pop_one();
  endtask
`endif

  task automatic test_random_frames();
    logic [7:0] d;
    logic       stop_b;
    logic       bad;
    model_q.delete();
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      stop_b = 1'($urandom_range(0, 1));
      bad = 1'($urandom_range(0, 1));
      i_scaler = 16'($urandom_range(0, 3));
      void'(model_push(d, ~stop_b, exp_perr(bad)));
      send_frame(d, stop_b, bad, 0, -1, -1, lat, seen, cap);
    end
    n_checks++;
    if (o_count !== 5'(model_q.size())) begin
      n_fail++; $display("FAIL rand_count got=%0d expected=%0d", o_count, model_q.size());
    end
    while (model_q.size() > 0) begin
      exp_t e;
      e = model_q.pop_front();
      n_checks++;
      if (o_rdata !== e.d || o_rferr !== e.ferr || o_rperr !== e.perr) begin
        n_fail++; $display("FAIL rand_entry got d=%h f=%b p=%b expected %h/%b/%b", o_rdata, o_rferr, o_rperr, e.d, e.ferr, e.perr);
      end
      pop_one();
    end
    i_scaler = 16'd4;
  endtask

  task automatic test_scaler_reset();
    i_scaler = 16'd1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1, 1'b0, 0, -1, -1, lat, seen, cap);
    n_checks++;
    if (o_count !== 5'd1 || o_rdata !== 8'h3C) begin
      n_fail++; $display("FAIL scaler1_entry got count=%0d d=%h expected 1/3c", o_count, o_rdata);
    end
    // Abort a frame half-way through with reset.
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy got=%b expected=1", o_busy); end
    i_nrst = 1'b0;
    @(posedge clk); #1;
    i_nrst = 1'b1;
    i_rx = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    n_checks++;
    if (o_count !== '0 || o_rvalid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reset got count=%0d v=%b busy=%b expected 0/0/0", o_count, o_rvalid, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_glitch();
    test_empty_passthrough();
    test_framing_break();
    test_overflow();
`ifdef UART_RX_MONITOR_PARITY_EN
    test_parity();
`endif
    test_random_frames();
    test_scaler_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
